// File: rtl/core_pkg.sv
// core_pkg: shared types for the multi-cycle core stage sequencer.
//   stage_e     - stage indices; also the bit position of each stage in the
//                 one-hot stage_active strobe
//   NUM_STAGES  - width of the stage strobe
//   ctrl_op_e   - kind of instruction sequence currently being run
//   CAUSE_*     - trap cause codes latched into fault_num
//   stage_onehot() - stage index to one-hot strobe
package core_pkg;

  typedef enum logic [2:0] {
    STG_FETCH      = 3'd0,
    STG_DECODE     = 3'd1,
    STG_READ       = 3'd2,
    STG_EXECUTE    = 3'd3,
    STG_MEMORY     = 3'd4,
    STG_WRITE_BACK = 3'd5,
    STG_UPDATE_PC  = 3'd6
  } stage_e;

  localparam int NUM_STAGES = 7;

  typedef enum logic [1:0] {
    CTRL_TRAP      = 2'b00,
    CTRL_INTERRUPT = 2'b01,
    CTRL_NORMAL    = 2'b11
  } ctrl_op_e;

  localparam logic [2:0] CAUSE_FETCH_ACCESS   = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL        = 3'd2;
  localparam logic [2:0] CAUSE_LOAD_MISALIGN  = 3'd4;
  localparam logic [2:0] CAUSE_LOAD_ACCESS    = 3'd5;
  localparam logic [2:0] CAUSE_STORE_MISALIGN = 3'd6;
  localparam logic [2:0] CAUSE_STORE_ACCESS   = 3'd7;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_e s);
    return NUM_STAGES'(1) << s;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: fixed-priority arbiter over the interrupt lines.
// Index 0 is the highest priority, so the lowest set index wins.
// Ports:
//   req_i    in  NUM_IRQ  level-sensitive requests
//   valid_o  out 1        at least one request is set
//   idx_o    out IDW      lowest set index (0 when none is set)
module irq_priority_encoder #(
  parameter int NUM_IRQ = 2
) (
  input  logic [NUM_IRQ-1:0]          req_i,
  output logic                        valid_o,
  output logic [$clog2(NUM_IRQ):0]    idx_o
);

  localparam int IDW = $clog2(NUM_IRQ) + 1;

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan from the top down so the lowest set index is the last write.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDW'(i);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: stage FSM of the multi-cycle core.
// Walks FETCH -> DECODE -> [READ] -> EXECUTE -> [MEMORY] -> WRITE_BACK ->
// UPDATE_PC, holds FETCH/MEMORY on the memory handshake (with an optional
// timeout), turns sampled faults into trap sequences, halts on a double fault
// and takes prioritised interrupts at UPDATE_PC.
//
// Optional feature: define CORE_SEQ_WFI_EN to enable the SLEEP state entered
// after a WFI instruction; without it WFI retires as a NOP.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stage_active      one-hot stage strobe (core_pkg::stage_e); 0 in SLEEP/HALT
//   control_op        NORMAL / TRAP / INTERRUPT sequence in progress
//   fault_num         latched trap cause
//   irq_id            latched index of the interrupt being taken
//   has_read/has_mem  decode flags selecting the optional READ/MEMORY stages
//   mem_req/mem_ready memory request and its completion handshake
//   illegal_fault, mem_addr_fault, mem_access_fault, mem_is_store  fault inputs
//   irq_pending, irq_global_en  interrupt requests and global enable
//   wfi_req           current instruction is WFI
//   retire            one-cycle pulse at UPDATE_PC of a NORMAL sequence
//   halted            sticky double-fault indication
//   dbg_state_o       raw FSM state for debug and checkers
//
// Handshake: a FETCH (NORMAL sequence) or MEMORY stage asserts mem_req and
// stays put until a cycle in which mem_ready=1; the stage completes on that
// clock edge. mem_ready outside those stages is ignored.
module core_sequencer
  import core_pkg::*;
#(
  parameter int NUM_IRQ     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [NUM_STAGES-1:0]      stage_active,
  output logic [1:0]                 control_op,
  output logic [2:0]                 fault_num,
  output logic [$clog2(NUM_IRQ):0]   irq_id,
  input  logic                       has_read,
  input  logic                       has_mem,
  output logic                       mem_req,
  input  logic                       mem_ready,
  input  logic                       illegal_fault,
  input  logic                       mem_addr_fault,
  input  logic                       mem_access_fault,
  input  logic                       mem_is_store,
  input  logic [NUM_IRQ-1:0]         irq_pending,
  input  logic                       irq_global_en,
  input  logic                       wfi_req,
  output logic                       retire,
  output logic                       halted,
  output logic [3:0]                 dbg_state_o
);

  localparam int IDW       = $clog2(NUM_IRQ) + 1;
  localparam int CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam bit   TO_EN   = (MEM_TIMEOUT > 0);

  // State codes 0..6 coincide with stage_e so the strobe decodes directly.
  localparam logic [3:0] S_FETCH      = 4'd0;
  localparam logic [3:0] S_DECODE     = 4'd1;
  localparam logic [3:0] S_READ       = 4'd2;
  localparam logic [3:0] S_EXECUTE    = 4'd3;
  localparam logic [3:0] S_MEMORY     = 4'd4;
  localparam logic [3:0] S_WRITE_BACK = 4'd5;
  localparam logic [3:0] S_UPDATE_PC  = 4'd6;
`ifdef CORE_SEQ_WFI_EN
  localparam logic [3:0] S_SLEEP      = 4'd7;
`endif
  localparam logic [3:0] S_HALT       = 4'd8;

  logic [3:0]     state_q, state_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [2:0]     fault_q, fault_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic           halted_q, halted_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           irq_valid;
  logic [IDW-1:0] irq_idx;
  logic           irq_take;
  logic           timeout_hit;
  logic           fault_hit;
  logic [2:0]     cause;
  logic           hold;
  logic [2:0]     mem_cause_access;
  logic [2:0]     mem_cause_misalign;

`ifdef CORE_SEQ_WFI_EN
  logic wfi_q, wfi_d;
`else
  logic unused_wfi;
  assign unused_wfi = wfi_req;
`endif

  irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_irq_enc (
    .req_i   (irq_pending),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  assign irq_take           = irq_global_en & irq_valid;
  assign timeout_hit        = TO_EN && (cnt_q == TO_LAST);
  assign mem_cause_access   = mem_is_store ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
  assign mem_cause_misalign = mem_is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    fault_d   = fault_q;
    irq_id_d  = irq_id_q;
    halted_d  = halted_q;
    fault_hit = 1'b0;
    cause     = '0;
    hold      = 1'b0;
`ifdef CORE_SEQ_WFI_EN
    wfi_d     = wfi_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (ctrl_q == CTRL_NORMAL) begin
          if (mem_ready) begin
            if (mem_access_fault) begin
              fault_hit = 1'b1;
              cause     = CAUSE_FETCH_ACCESS;
            end else begin
              state_d = S_DECODE;
            end
          end else if (timeout_hit) begin
            fault_hit = 1'b1;
            cause     = CAUSE_FETCH_ACCESS;
          end else begin
            hold = 1'b1;
          end
        end else begin
          // Trap/interrupt entry: the datapath injects ECALL, no bus fetch.
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Decode flags come straight from the decoder and are used on the
        // DECODE exit edge to choose the next stage.
        if (illegal_fault) begin
          fault_hit = 1'b1;
          cause     = CAUSE_ILLEGAL;
        end else begin
          state_d = has_read ? S_READ : S_EXECUTE;
        end
      end

      S_READ: state_d = S_EXECUTE;

      S_EXECUTE: begin
`ifdef CORE_SEQ_WFI_EN
        wfi_d = wfi_req;
`endif
        if (illegal_fault) begin
          fault_hit = 1'b1;
          cause     = CAUSE_ILLEGAL;
        end else begin
          state_d = has_mem ? S_MEMORY : S_WRITE_BACK;
        end
      end

      S_MEMORY: begin
        // Misalignment is known up front and outranks the bus response.
        if (mem_addr_fault) begin
          fault_hit = 1'b1;
          cause     = mem_cause_misalign;
        end else if (mem_ready) begin
          if (mem_access_fault) begin
            fault_hit = 1'b1;
            cause     = mem_cause_access;
          end else begin
            state_d = S_WRITE_BACK;
          end
        end else if (timeout_hit) begin
          fault_hit = 1'b1;
          cause     = mem_cause_access;
        end else begin
          hold = 1'b1;
        end
      end

      S_WRITE_BACK: state_d = S_UPDATE_PC;

      S_UPDATE_PC: begin
        state_d = S_FETCH;
        if (irq_take) begin
          ctrl_d   = CTRL_INTERRUPT;
          irq_id_d = irq_idx;
        end else begin
          ctrl_d = CTRL_NORMAL;
        end
`ifdef CORE_SEQ_WFI_EN
        // Arbitration is deferred to wake-up when the instruction was WFI.
        if (wfi_q) begin
          state_d  = S_SLEEP;
          ctrl_d   = CTRL_NORMAL;
          irq_id_d = irq_id_q;
        end
        wfi_d = 1'b0;
`endif
      end

`ifdef CORE_SEQ_WFI_EN
      S_SLEEP: begin
        // Any pending line wakes the core, even with interrupts disabled.
        if (irq_valid) begin
          state_d = S_FETCH;
          if (irq_take) begin
            ctrl_d   = CTRL_INTERRUPT;
            irq_id_d = irq_idx;
          end else begin
            ctrl_d = CTRL_NORMAL;
          end
        end
      end
`endif

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    if (fault_hit) begin
`ifdef CORE_SEQ_WFI_EN
      wfi_d = 1'b0;
`endif
      if (ctrl_q == CTRL_NORMAL) begin
        state_d = S_FETCH;
        ctrl_d  = CTRL_TRAP;
        fault_d = cause;
      end else begin
        // Fault inside a trap/interrupt sequence: double fault.
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    end
  end

  // Wait counter only advances while a stage is held on the handshake and
  // clears on any exit from that stage.
  assign cnt_d = (TO_EN && hold) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ctrl_q   <= CTRL_NORMAL;
      fault_q  <= '0;
      irq_id_q <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
`ifdef CORE_SEQ_WFI_EN
      wfi_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      fault_q  <= fault_d;
      irq_id_q <= irq_id_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
`ifdef CORE_SEQ_WFI_EN
      wfi_q    <= wfi_d;
`endif
    end
  end

  always_comb begin
    stage_active = '0;
    if (state_q <= S_UPDATE_PC) stage_active = stage_onehot(stage_e'(state_q[2:0]));
  end

  assign mem_req     = ((state_q == S_FETCH) && (ctrl_q == CTRL_NORMAL)) || (state_q == S_MEMORY);
  assign retire      = (state_q == S_UPDATE_PC) && (ctrl_q == CTRL_NORMAL);
  assign control_op  = ctrl_q;
  assign fault_num   = fault_q;
  assign irq_id      = irq_id_q;
  assign halted      = halted_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench for core_sequencer (NUM_IRQ=4,
// MEM_TIMEOUT=4). Walks single-cycle, waiting, timeout, fault, interrupt,
// double-fault, reset-mid-wait and WFI instruction sequences and compares the
// stage strobe and sequencer outputs with hand-computed values.
module tb_core_sequencer;

  localparam int NUM_IRQ = 4;

  localparam logic [6:0] F = 7'b0000001;
  localparam logic [6:0] D = 7'b0000010;
  localparam logic [6:0] R = 7'b0000100;
  localparam logic [6:0] E = 7'b0001000;
  localparam logic [6:0] M = 7'b0010000;
  localparam logic [6:0] W = 7'b0100000;
  localparam logic [6:0] U = 7'b1000000;

  logic               clk = 1'b0;
  logic               reset;
  logic [6:0]         stage_active;
  logic [1:0]         control_op;
  logic [2:0]         fault_num;
  logic [2:0]         irq_id;
  logic               has_read;
  logic               has_mem;
  logic               mem_req;
  logic               mem_ready;
  logic               illegal_fault;
  logic               mem_addr_fault;
  logic               mem_access_fault;
  logic               mem_is_store;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               irq_global_en;
  logic               wfi_req;
  logic               retire;
  logic               halted;
  logic [3:0]         dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  core_sequencer #(.NUM_IRQ(NUM_IRQ), .MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .stage_active     (stage_active),
    .control_op       (control_op),
    .fault_num        (fault_num),
    .irq_id           (irq_id),
    .has_read         (has_read),
    .has_mem          (has_mem),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .illegal_fault    (illegal_fault),
    .mem_addr_fault   (mem_addr_fault),
    .mem_access_fault (mem_access_fault),
    .mem_is_store     (mem_is_store),
    .irq_pending      (irq_pending),
    .irq_global_en    (irq_global_en),
    .wfi_req          (wfi_req),
    .retire           (retire),
    .halted           (halted),
    .dbg_state_o      (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver / checking tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_stage(input string tag, input logic [6:0] exp);
    check_eq(tag, 32'(stage_active), 32'(exp));
    tick();
  endtask

  // Five-stage sequence with neither READ nor MEMORY.
  task automatic run_plain(input string tag);
    has_read = 1'b0;
    has_mem  = 1'b0;
    expect_stage({tag, "_f"}, F);
    expect_stage({tag, "_d"}, D);
    expect_stage({tag, "_e"}, E);
    expect_stage({tag, "_w"}, W);
    check_eq({tag, "_no_retire"}, 32'(retire), 32'd0);
    expect_stage({tag, "_u"}, U);
  endtask

  initial begin
    int retire_cnt;
    int sleep_cnt;

    reset            = 1'b1;
    has_read         = 1'b0;
    has_mem          = 1'b0;
    mem_ready        = 1'b0;
    illegal_fault    = 1'b0;
    mem_addr_fault   = 1'b0;
    mem_access_fault = 1'b0;
    mem_is_store     = 1'b0;
    irq_pending      = '0;
    irq_global_en    = 1'b0;
    wfi_req          = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_stage",  32'(stage_active), 32'(F));
    check_eq("rst_ctrl",   32'(control_op),   32'h3);
    check_eq("rst_fault",  32'(fault_num),    32'd0);
    check_eq("rst_irq_id", 32'(irq_id),       32'd0);
    check_eq("rst_halted", 32'(halted),       32'd0);
    check_eq("rst_retire", 32'(retire),       32'd0);
    check_eq("rst_memreq", 32'(mem_req),      32'd1);

    // 1. ADD: READ used, MEMORY skipped, ready always high
    has_read  = 1'b1;
    mem_ready = 1'b1;
    exp_q = '{F, D, R, E, W, U};
    retire_cnt = 0;
    while (exp_q.size() > 0) begin
      logic [6:0] exp_s;
      exp_s = exp_q.pop_front();
      if (retire) retire_cnt++;
      expect_stage("t1_seq", exp_s);
    end
    check_eq("t1_back_fetch", 32'(stage_active), 32'(F));
    check_eq("t1_retire_once", 32'(retire_cnt), 32'd1);

    // 2. LW: MEMORY waits 3 cycles, completes on the 4th
    has_mem = 1'b1;
    expect_stage("t2_f", F);
    expect_stage("t2_d", D);
    mem_ready = 1'b0;
    expect_stage("t2_r", R);
    expect_stage("t2_e", E);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_memreq", 32'(mem_req), 32'd1);
      expect_stage("t2_mwait", M);
    end
    mem_ready = 1'b1;
    expect_stage("t2_mdone", M);
    expect_stage("t2_wb", W);
    check_eq("t2_retire", 32'(retire), 32'd1);
    expect_stage("t2_u", U);

    // 3. Store timeout in MEMORY -> TRAP with cause 7
    has_read     = 1'b0;
    mem_is_store = 1'b1;
    expect_stage("t3_f", F);
    mem_ready = 1'b0;
    expect_stage("t3_d", D);
    expect_stage("t3_e", E);
    for (int i = 0; i < 4; i++) expect_stage("t3_mwait", M);
    check_eq("t3_stage", 32'(stage_active), 32'(F));
    check_eq("t3_ctrl",  32'(control_op),   32'h0);
    check_eq("t3_fault", 32'(fault_num),    32'd7);
    check_eq("t3_memreq", 32'(mem_req),     32'd0);
    mem_is_store = 1'b0;
    // Trap FETCH takes one cycle even without mem_ready.
    run_plain("t3_trap");
    check_eq("t3_ret_ctrl", 32'(control_op), 32'h3);

    // Fetch access fault in the same cycle as mem_ready: fault wins
    mem_ready        = 1'b1;
    mem_access_fault = 1'b1;
    tick();
    mem_access_fault = 1'b0;
    check_eq("tf_stage", 32'(stage_active), 32'(F));
    check_eq("tf_ctrl",  32'(control_op),   32'h0);
    check_eq("tf_fault", 32'(fault_num),    32'd1);
    run_plain("tf_trap");

    // 4. Interrupt raised mid-instruction, taken at UPDATE_PC
    expect_stage("t4_f", F);
    irq_pending   = 4'b1010;
    irq_global_en = 1'b1;
    expect_stage("t4_d", D);
    check_eq("t4_mid_ctrl", 32'(control_op), 32'h3);
    expect_stage("t4_e", E);
    expect_stage("t4_w", W);
    check_eq("t4_retire", 32'(retire), 32'd1);
    expect_stage("t4_u", U);
    check_eq("t4_ctrl",   32'(control_op), 32'h1);
    check_eq("t4_irq_id", 32'(irq_id),     32'd1);
    check_eq("t4_memreq", 32'(mem_req),    32'd0);
    expect_stage("t4i_f", F);
    expect_stage("t4i_d", D);
    expect_stage("t4i_e", E);
    irq_global_en = 1'b0;
    expect_stage("t4i_w", W);
    check_eq("t4i_no_retire", 32'(retire), 32'd0);
    expect_stage("t4i_u", U);
    check_eq("t4_masked_ctrl", 32'(control_op), 32'h3);
    irq_pending = '0;

    // 5. Illegal in DECODE -> TRAP, then illegal in trap DECODE -> HALT
    expect_stage("t5_f", F);
    illegal_fault = 1'b1;
    expect_stage("t5_d", D);
    illegal_fault = 1'b0;
    check_eq("t5_ctrl",  32'(control_op), 32'h0);
    check_eq("t5_fault", 32'(fault_num),  32'd2);
    expect_stage("t5_trap_f", F);
    illegal_fault = 1'b1;
    expect_stage("t5_trap_d", D);
    illegal_fault = 1'b0;
    check_eq("t5_halt_stage",  32'(stage_active), 32'd0);
    check_eq("t5_halted",      32'(halted),       32'd1);
    check_eq("t5_halt_memreq", 32'(mem_req),      32'd0);
    tick();
    tick();
    check_eq("t5_sticky", 32'(halted), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_rst_stage",  32'(stage_active), 32'(F));
    check_eq("t5_rst_halted", 32'(halted),       32'd0);
    check_eq("t5_rst_ctrl",   32'(control_op),   32'h3);

    // Reset while MEMORY waits; a ready at the reset edge is ignored
    has_mem = 1'b1;
    expect_stage("tr_f", F);
    mem_ready = 1'b0;
    expect_stage("tr_d", D);
    expect_stage("tr_e", E);
    expect_stage("tr_m1", M);
    check_eq("tr_m2", 32'(stage_active), 32'(M));
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("tr_stage", 32'(stage_active), 32'(F));
    check_eq("tr_ctrl",  32'(control_op),   32'h3);
    has_mem = 1'b0;

    // 6. WFI with interrupts disabled and nothing pending
    expect_stage("t6_f", F);
    expect_stage("t6_d", D);
    wfi_req = 1'b1;
    expect_stage("t6_e", E);
    wfi_req = 1'b0;
    check_eq("t6_retire", 32'(retire), 32'd0);
    expect_stage("t6_w", W);
    check_eq("t6_retire_u", 32'(retire), 32'd1);
    expect_stage("t6_u", U);
`ifdef CORE_SEQ_WFI_EN
    sleep_cnt = 0;
    check_eq("t6_sleep_memreq", 32'(mem_req), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) irq_pending = 4'b0001;
      if (stage_active == 7'd0) sleep_cnt++;
      tick();
    end
    check_eq("t6_sleep_cycles", 32'(sleep_cnt), 32'd10);
    check_eq("t6_wake_stage",   32'(stage_active), 32'(F));
    check_eq("t6_wake_ctrl",    32'(control_op),   32'h3);
    irq_pending = '0;
`else
    sleep_cnt = 0;
    check_eq("t6_nosleep_stage", 32'(stage_active), 32'(F));
    check_eq("t6_nosleep_ctrl",  32'(control_op),   32'h3);
    check_eq("t6_sleep_cycles",  32'(sleep_cnt),    32'd0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
